// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit over a single-port big-endian data RAM with sub-word extract and merge.
// Define DMEM_BYTE_WRITE_EN for byte-lane write enables; otherwise sub-word stores use read-modify-write.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RESP} state_t;
`ifdef DMEM_BYTE_WRITE_EN
    localparam state_t SUB_STORE = WR;
`else
    localparam state_t SUB_STORE = RMW_RD;
    logic [31:0] r_old;
    logic [31:0] w_merged;
`endif
    state_t                r_state;
    logic                  r_we, r_uns;
    logic [1:0]            r_size, r_off;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic                  w_bad, w_unused;
    logic [31:0]           w_word, w_sh, w_ext, w_wd;
    logic [3:0]            w_be;

    assign req_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign w_unused  = ^{req_addr[31:ADDR_WIDTH+2]};
    assign w_bad     = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_word    = r_mem[r_idx];
    // Shifting the addressed lane to the top makes byte and half extraction offset-independent.
    assign w_sh      = w_word << {r_off, 3'b000};
    assign w_ext     = r_size == 2'b00 ? {{24{~r_uns & w_sh[31]}}, w_sh[31:24]} :
                       r_size == 2'b01 ? {{16{~r_uns & w_sh[31]}}, w_sh[31:16]} : w_word;
    assign w_be      = r_size == 2'b00 ? 4'b1000 >> r_off :
                       r_size == 2'b01 ? (r_off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    assign w_wd      = r_size == 2'b00 ? {4{r_wdata[7:0]}} :
                       r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;

`ifdef DMEM_BYTE_WRITE_EN
    always_ff @(posedge clk) begin
        if (!rst && r_state == WR)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[r_idx][i*8 +: 8] <= w_wd[i*8 +: 8];
    end
`else
    always_comb begin
        w_merged = r_old;
        for (int i = 0; i < 4; i++)
            if (w_be[i]) w_merged[i*8 +: 8] = w_wd[i*8 +: 8];
    end

    // The rst guard drops a write whose commit edge coincides with reset.
    always_ff @(posedge clk) begin
        if (!rst && r_state == WR) r_mem[r_idx] <= w_merged;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_idx      <= '0;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifndef DMEM_BYTE_WRITE_EN
            r_old      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_uns   <= req_unsigned;
                    r_size  <= req_size;
                    r_off   <= req_addr[1:0];
                    r_idx   <= req_addr[ADDR_WIDTH+1:2];
                    r_wdata <= req_wdata;
                    if (w_bad) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        r_state <= !req_we ? RD : req_size == 2'b10 ? WR : SUB_STORE;
                    end
                end
                RD: begin
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= w_ext;
                end
`ifndef DMEM_BYTE_WRITE_EN
                RMW_RD: begin
                    r_old   <= w_word;
                    r_state <= WR;
                end
`endif
                WR: begin
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table-driven bench for dmem_lsu with a response scoreboard and latency checks.
module tb_dmem_lsu;
`ifdef DMEM_BYTE_WRITE_EN
    localparam int SUB = 2;
`else
    localparam int SUB = 3;
`endif
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    int          cyc = 0, n_tests = 0, n_fail = 0, n_resp = 0, last_resp_cyc = -1;
    exp_t        sbq[$];
    vec_t        tbl[$];

    dmem_lsu #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t v(input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic e);
        vec_t t;
        t.we = we; t.size = sz; t.uns = u; t.addr = a; t.wdata = wd; t.rdata = rd; t.err = e;
        t.lat = e ? 1 : (!we || sz == 2'b10) ? 2 : SUB;
        return t;
    endfunction

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            exp_t e;
            n_resp++;
            last_resp_cyc = cyc;
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("err#%0d", e.id), 32'(resp_err), 32'(e.err));
                if (e.chk_rd) chk($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
                chk($sformatf("latency#%0d", e.id), 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        req_we = t.we; req_size = t.size; req_unsigned = t.uns;
        req_addr = t.addr; req_wdata = t.wdata; req_valid = 1'b1;
    endtask

    task automatic wait_empty(input int id);
        for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
        chk($sformatf("drain#%0d", id), 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic issue(input vec_t t, input int id);
        step();
        drive(t);
        for (int k = 0; k < 50 && !req_ready; k++) step();
        if (!req_ready) chk($sformatf("ready#%0d", id), 32'(req_ready), 32'd1);
        sbq.push_back('{t.rdata, t.err, !t.we || t.err, cyc, t.lat, id});
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_empty(id);
    endtask

    initial begin
        tbl.push_back(v(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h10, 0, 32'h11223344, 0));
        tbl.push_back(v(1, 2'b10, 0, 32'h20, 32'h8122F344, 0, 0));
        tbl.push_back(v(0, 2'b00, 0, 32'h20, 0, 32'hFFFFFF81, 0));
        tbl.push_back(v(0, 2'b00, 1, 32'h20, 0, 32'h00000081, 0));
        tbl.push_back(v(0, 2'b00, 0, 32'h21, 0, 32'h00000022, 0));
        tbl.push_back(v(0, 2'b00, 0, 32'h22, 0, 32'hFFFFFFF3, 0));
        tbl.push_back(v(0, 2'b00, 0, 32'h23, 0, 32'h00000044, 0));
        tbl.push_back(v(0, 2'b01, 0, 32'h22, 0, 32'hFFFFF344, 0));
        tbl.push_back(v(0, 2'b01, 1, 32'h22, 0, 32'h0000F344, 0));
        tbl.push_back(v(0, 2'b01, 1, 32'h20, 0, 32'h00008122, 0));
        tbl.push_back(v(1, 2'b00, 0, 32'h21, 32'h000000AB, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h81ABF344, 0));
        tbl.push_back(v(1, 2'b01, 0, 32'h20, 32'h00001234, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h1234F344, 0));
        tbl.push_back(v(1, 2'b00, 1, 32'h23, 32'hFFFFFF55, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h1234F355, 0));
        tbl.push_back(v(1, 2'b01, 0, 32'h22, 32'hABCD5678, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h12345678, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h22, 0, 32'h0, 1));
        tbl.push_back(v(1, 2'b01, 0, 32'h23, 32'h0000BEEF, 32'h0, 1));
        tbl.push_back(v(0, 2'b01, 0, 32'h21, 0, 32'h0, 1));
        tbl.push_back(v(1, 2'b10, 0, 32'h21, 32'hCAFEF00D, 32'h0, 1));
        tbl.push_back(v(0, 2'b11, 0, 32'h20, 0, 32'h0, 1));
        tbl.push_back(v(1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(v(0, 2'b10, 0, 32'h20, 0, 32'h12345678, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h80001020, 0, 32'h12345678, 0));
        tbl.push_back(v(1, 2'b10, 0, 32'hFFC, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(0, 2'b10, 0, 32'h7FFC, 0, 32'hDEADBEEF, 0));
        tbl.push_back(v(0, 2'b00, 1, 32'h10, 0, 32'h00000011, 0));

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("init_valid", 32'(resp_valid), 32'd0);
        chk("init_rdata", resp_rdata, 32'd0);
        chk("init_err", 32'(resp_err), 32'd0);
        chk("init_ready", 32'(req_ready), 32'd1);

        foreach (tbl[i]) issue(tbl[i], i);

        // reset during each cycle of an in-flight sub-word store to word 0x20 (0x12345678)
        for (int d = 0; d < SUB - 1; d++) begin
            step();
            drive(v(1, 2'b00, 0, 32'h20, 32'h00000077, 0, 0));
            chk("abort_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            chk("abort_busy_pre", 32'(busy), 32'd1);
            repeat (d) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_ready_now", 32'(req_ready), 32'd1);
            chk("abort_valid", 32'(resp_valid), 32'd0);
            chk("abort_rdata", resp_rdata, 32'd0);
            @(posedge clk);
            step();
            rst = 1'b0;
            repeat (4) step();
            issue(v(0, 2'b10, 0, 32'h20, 0, 32'h12345678, 0), 200 + d);
        end

        // two requests presented back to back with req_valid held high
        begin
            int r0;
            r0 = n_resp;
            step();
            drive(v(0, 2'b10, 0, 32'h10, 0, 32'h11223344, 0));
            chk("b2b_ready0", 32'(req_ready), 32'd1);
            sbq.push_back('{32'h11223344, 1'b0, 1'b1, cyc, 2, 300});
            @(posedge clk);
            #1 req_addr = 32'h20;
            for (int k = 0; k < 2; k++) begin
                step();
                chk("b2b_ready_low", 32'(req_ready), 32'd0);
                chk("b2b_busy", 32'(busy), 32'd1);
            end
            step();
            chk("b2b_ready_high", 32'(req_ready), 32'd1);
            chk("b2b_after_resp", 32'(last_resp_cyc), 32'(cyc - 1));
            sbq.push_back('{32'h12345678, 1'b0, 1'b1, cyc, 2, 301});
            @(posedge clk);
            #1 req_valid = 1'b0;
            step();
            chk("b2b_ready_low2", 32'(req_ready), 32'd0);
            wait_empty(301);
            repeat (3) step();
            chk("b2b_resp_count", 32'(n_resp - r0), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Data-memory load/store unit between the control unit's memory interface and an internal single-port synchronous data RAM. It accepts one load or store request at a time through a valid/ready handshake and reports completion with a one-cycle response strobe. It performs byte/halfword lane extraction with sign or zero extension, and merges sub-word stores by read-modify-write. Memory byte order is big-endian: byte offset 0 is bits [31:24].

## Interface
- ADDR_WIDTH, default 10: word-address bits; the RAM holds 2**ADDR_WIDTH 32-bit words.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; the requester holds all req_* fields stable until accepted.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, higher bits are ignored.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  32  extended load data; registered, held until the next response.
- resp_err  out  1  misalignment or illegal size; valid with resp_valid.
- busy  out  1  state != IDLE; used as the PC stall.

## Operation
- A request is accepted on the edge where req_valid && req_ready. The unit latches we, size, unsigned, word index, offset = addr[1:0], and wdata.
- Error check at accept:
  - size 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] != 0 → error.
  - On error: no RAM access, resp_rdata = 0, resp_err = 1.
- FSM states: IDLE, RD, WR, RMW_RD, RESP. Transitions from IDLE on accept:
  - Error → RESP.
  - Load → RD.
  - Store word → WR.
  - Store byte/half → RMW_RD.
- RD: issue the RAM read; → RESP.
- RMW_RD: issue the RAM read; → WR.
- WR: write the word; → RESP.
  - Word store writes wdata.
  - Byte store: the merge replaces lane `offset` with wdata[7:0].
  - Half store: offset 0 replaces [31:16], offset 2 replaces [15:0], with wdata[15:0].
- RESP: resp_valid = 1 for exactly one cycle; → IDLE.
- Load extraction (registered into resp_rdata when entering RESP):
  - Byte at offset k = rdata[31-8k -: 8].
  - Half at offset 0 = [31:16], at offset 2 = [15:0].
  - Word is passed through.
  - The sign bit is the MSB of the extracted field, ignored when req_unsigned = 1.
- req_unsigned is ignored for stores. req_valid while busy is ignored; there is no buffering.
- RAM contents are not reset and are zero at configuration.

## Timing
- Reset values:
  - req_ready = 1 (state IDLE).
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
- Latency from the accept edge N to the resp_valid cycle:
  - Error: N+1.
  - Load: N+2.
  - Word store: N+2.
  - Sub-word store: N+3.
- Throughput: the next accept is possible in the cycle after RESP. There is no overlap.
- Store write commits on the rising edge that ends the WR cycle.
- Reset mid-operation:
  - Asynchronous reset returns to IDLE immediately.
  - A write whose commit edge coincides with asserted rst is suppressed.
  - Any pending RMW is discarded, so memory keeps its pre-request contents.
  - No response is generated for the aborted request.
- Address wrap: bits above ADDR_WIDTH+1 alias onto the RAM without error.

## Configuration
- DMEM_BYTE_WRITE_EN defined:
  - The RAM uses 4 byte-lane write enables.
  - Byte/half stores go IDLE → WR → RESP with latency 2, and never read the RAM.
  - RMW_RD is unused.
- DMEM_BYTE_WRITE_EN undefined:
  - Whole-word writes only.
  - Sub-word stores use RMW_RD with latency 3, as described above.

## Test plan
- Store word then load word:
  - After reset, sw 0x11223344 @0x10 → resp_valid at N+2, err = 0.
  - lw @0x10 → resp_rdata = 0x11223344 at N+2.
- Load extraction, after sw 0x8122F344 @0x20:
  - lb @0x20 → 0xFFFFFF81; lbu @0x20 → 0x00000081.
  - lb @0x21 → 0x00000022.
  - lh @0x22 → 0xFFFFF344; lhu @0x22 → 0x0000F344.
- Sub-word stores:
  - sb wdata 0x000000AB @0x21 → lw @0x20 returns 0x81ABF344.
  - sb completes at N+3 without the macro, N+2 with it.
  - sh 0x00001234 @0x20 → lw returns 0x1234F344.
- Misaligned and illegal requests:
  - lw @0x22 → resp at N+1, err = 1, rdata = 0.
  - sh @0x23 → err = 1, and a following lw shows memory unchanged.
  - size 11 → err = 1.
- Reset during sub-word store: assert rst during RMW_RD or WR of an sb @0x20 → no resp_valid, busy = 0 immediately, and a later lw returns the old word.
- Back-to-back handshake: hold req_valid with two queued requests → the second is accepted in the first IDLE cycle after RESP, exactly one resp_valid per accept, and req_ready = 0 throughout busy.
